// File: rtl/udma_uart_lsu_pkg.sv
// Shared constants and state encoding for the UART load-store responder.
package udma_uart_lsu_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;

  localparam int TMO_W = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    DATA      = 3'd2,
    MEM_REQ   = 3'd3,
    MEM_WAIT  = 3'd4,
    RESP_HDR  = 3'd5,
    RESP_DATA = 3'd6
  } lsu_state_e;

endpackage

// File: rtl/udma_uart_lsu_timeout.sv
// Inter-byte timeout counter: clears on demand, counts while enabled,
// flags the terminal count one cycle before it would reach LIMIT.
module udma_uart_lsu_timeout
  import udma_uart_lsu_pkg::*;
#(
  parameter int unsigned LIMIT = 65535
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [TMO_W-1:0] TC_VAL = TMO_W'(LIMIT - 1);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign tc_o = en_i && (cnt_q == TC_VAL);

endmodule

// File: rtl/udma_uart_lsu_resp.sv
// UART-side target of the load-store link: parses W/R packets from the rx
// byte stream, runs one 32-bit memory access and streams the reply to tx.
module udma_uart_lsu_resp
  import udma_uart_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 65535,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_be_o,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_err_i,
  output logic              busy_o,
  output logic              err_o,
  input  logic              err_clr_i
);

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [7:0]        hdr_q, hdr_d;
  logic [1:0]        byteCnt_q, byteCnt_d;
  logic              gotRsp_q, gotRsp_d;
  logic              err_q, err_d;
  logic              errSet;
  logic              rxFire;
  logic              inRxPhase;
  logic              tmoTc;

  // Reset is folded in so the accept strobe stays low while reset is held.
  assign rx_ready_o = !rst_i && (!en_i || state_q == IDLE || state_q == ADDR || state_q == DATA);
  assign rxFire     = rx_valid_i && rx_ready_o;
  assign inRxPhase  = (state_q == ADDR) || (state_q == DATA);

  udma_uart_lsu_timeout #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (rxFire || (state_d != state_q) || !inRxPhase),
    .en_i  (inRxPhase),
    .tc_o  (tmoTc)
  );

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    hdr_d     = hdr_q;
    byteCnt_d = byteCnt_q;
    gotRsp_d  = gotRsp_q;
    errSet    = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_i && rx_valid_i) begin
          if (rx_data_i == CMD_WR || rx_data_i == CMD_RD) begin
            state_d   = ADDR;
            we_d      = (rx_data_i == CMD_WR);
            byteCnt_d = 2'd0;
          end else begin
            state_d = RESP_HDR;
            we_d    = 1'b0;
            hdr_d   = RSP_ERR;
            errSet  = 1'b1;
          end
        end
      end
      ADDR, DATA: begin
        // A byte landing on the terminal count wins over the timeout.
        if (!en_i) begin
          state_d = IDLE;
        end else if (rx_valid_i) begin
          byteCnt_d = byteCnt_q + 2'd1;
          if (state_q == ADDR)
            addr_d = {addr_q[ADDR_W-9:0], rx_data_i};
          else
            wdata_d = {wdata_q[23:0], rx_data_i};
          if (byteCnt_q == 2'd3)
            state_d = (state_q == ADDR && we_q) ? DATA : MEM_REQ;
        end else if (tmoTc) begin
          state_d = IDLE;
          errSet  = 1'b1;
        end
      end
      MEM_REQ: begin
        if (mem_gnt_i) begin
          state_d = MEM_WAIT;
          if (mem_rvalid_i) begin
            gotRsp_d = 1'b1;
            rdata_d  = mem_rdata_i;
            hdr_d    = mem_err_i ? RSP_ERR : RSP_OK;
            errSet   = mem_err_i;
          end
        end
      end
      MEM_WAIT: begin
        if (gotRsp_q) begin
          state_d  = RESP_HDR;
          gotRsp_d = 1'b0;
        end else if (mem_rvalid_i) begin
          state_d = RESP_HDR;
          rdata_d = mem_rdata_i;
          hdr_d   = mem_err_i ? RSP_ERR : RSP_OK;
          errSet  = mem_err_i;
        end
      end
      RESP_HDR: begin
        if (tx_ready_i) begin
          byteCnt_d = 2'd0;
          state_d   = (hdr_q == RSP_OK && !we_q) ? RESP_DATA : IDLE;
        end
      end
      RESP_DATA: begin
        if (tx_ready_i) begin
          byteCnt_d = byteCnt_q + 2'd1;
          if (byteCnt_q == 2'd3)
            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    err_d = errSet ? 1'b1 : (err_clr_i ? 1'b0 : err_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      hdr_q     <= '0;
      byteCnt_q <= '0;
      gotRsp_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      hdr_q     <= hdr_d;
      byteCnt_q <= byteCnt_d;
      gotRsp_q  <= gotRsp_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    tx_data_o = 8'h00;
    if (state_q == RESP_HDR) begin
      tx_data_o = hdr_q;
    end else if (state_q == RESP_DATA) begin
      case (byteCnt_q)
        2'd0:    tx_data_o = rdata_q[31:24];
        2'd1:    tx_data_o = rdata_q[23:16];
        2'd2:    tx_data_o = rdata_q[15:8];
        default: tx_data_o = rdata_q[7:0];
      endcase
    end
  end

  assign tx_valid_o  = (state_q == RESP_HDR) || (state_q == RESP_DATA);
  assign mem_req_o   = (state_q == MEM_REQ);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_be_o    = 4'hF;
  assign busy_o      = (state_q != IDLE);
  assign err_o       = err_q;

endmodule

// File: tb/tb_udma_uart_lsu_resp.sv
// Directed bench for udma_uart_lsu_resp with a 16-cycle inter-byte timeout.
module tb_udma_uart_lsu_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  rxData;
  logic        rxValid;
  logic        rxReady;
  logic [7:0]  txData;
  logic        txValid;
  logic        txReady;
  logic        memReq;
  logic        memGnt;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [3:0]  memBe;
  logic        memRvalid;
  logic [31:0] memRdata;
  logic        memErr;
  logic        busy;
  logic        errFlag;
  logic        errClr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  udma_uart_lsu_resp #(
    .TIMEOUT_CYC (16),
    .ADDR_W      (32)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .rx_data_i    (rxData),
    .rx_valid_i   (rxValid),
    .rx_ready_o   (rxReady),
    .tx_data_o    (txData),
    .tx_valid_o   (txValid),
    .tx_ready_i   (txReady),
    .mem_req_o    (memReq),
    .mem_gnt_i    (memGnt),
    .mem_we_o     (memWe),
    .mem_addr_o   (memAddr),
    .mem_wdata_o  (memWdata),
    .mem_be_o     (memBe),
    .mem_rvalid_i (memRvalid),
    .mem_rdata_i  (memRdata),
    .mem_err_i    (memErr),
    .busy_o       (busy),
    .err_o        (errFlag),
    .err_clr_i    (errClr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b, output bit ok);
    rxData  = b;
    rxValid = 1'b1;
    ok      = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (rxReady) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
    rxValid = 1'b0;
  endtask

  task automatic send_pkt(input logic [71:0] v, input int n, output bit ok);
    bit one;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      applyStimulus(v[8*(n-1-i) +: 8], one);
      ok = ok & one;
    end
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (memReq) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic mem_respond(input logic [31:0] data, input logic err, input bit sameCycle);
    memGnt = 1'b1;
    if (sameCycle) begin
      memRvalid = 1'b1;
      memRdata  = data;
      memErr    = err;
    end
    tick();
    memGnt = 1'b0;
    if (!sameCycle) begin
      memRvalid = 1'b1;
      memRdata  = data;
      memErr    = err;
      tick();
    end
    memRvalid = 1'b0;
    memErr    = 1'b0;
  endtask

  task automatic recv_byte(output logic [7:0] b, output bit ok);
    ok = 1'b0;
    b  = 8'h00;
    for (int i = 0; i < 50; i++) begin
      if (txValid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    b       = txData;
    txReady = 1'b1;
    tick();
    txReady = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (memReq !== 1'b0 || txValid !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_ctrl req=%b txv=%b busy=%b exp=000", memReq, txValid, busy); end
    checks++; if (errFlag !== 1'b0 || rxReady !== 1'b0) begin failures++; $display("[TB] FAIL reset_flags err=%b rdy=%b exp=00", errFlag, rxReady); end
    checks++; if (memBe !== 4'hF) begin failures++; $display("[TB] FAIL reset_be got=%h exp=f", memBe); end
    checks++; if (memAddr !== 32'h0 || txData !== 8'h00 || memWe !== 1'b0) begin failures++; $display("[TB] FAIL reset_data addr=%h tx=%h we=%b exp=0", memAddr, txData, memWe); end
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++; if (rxReady !== 1'b1) begin failures++; $display("[TB] FAIL idle_ready got=%b exp=1", rxReady); end
  endtask

  task automatic test_store();
    bit ok;
    logic [7:0] b;
    send_pkt(72'h57_00001000_DEADBEEF, 9, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL store_send got=stalled exp=accepted"); end
    wait_req(ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL store_req got=0 exp=1"); end
    checks++; if (memAddr !== 32'h0000_1000) begin failures++; $display("[TB] FAIL store_addr got=%h exp=00001000", memAddr); end
    checks++; if (memWdata !== 32'hDEAD_BEEF || memWe !== 1'b1) begin failures++; $display("[TB] FAIL store_wdata got=%h we=%b exp=deadbeef we=1", memWdata, memWe); end
    mem_respond(32'h0, 1'b0, 1'b0);
    recv_byte(b, ok);
    checks++; if (!ok || b !== 8'h4B) begin failures++; $display("[TB] FAIL store_resp got=%h ok=%b exp=4b", b, ok); end
    checks++; if (txValid !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL store_done txv=%b busy=%b exp=00", txValid, busy); end
  endtask

  task automatic test_load();
    bit ok;
    logic [7:0] b;
    logic [39:0] exp;
    exp = 40'h4B_12345678;
    send_pkt(72'h52_00002004, 5, ok);
    wait_req(ok);
    checks++; if (!ok || memAddr !== 32'h0000_2004 || memWe !== 1'b0) begin failures++; $display("[TB] FAIL load_req ok=%b addr=%h we=%b exp=1 00002004 0", ok, memAddr, memWe); end
    mem_respond(32'h1234_5678, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      recv_byte(b, ok);
      checks++; if (!ok || b !== exp[8*(4-i) +: 8]) begin failures++; $display("[TB] FAIL load_byte%0d got=%h exp=%h", i, b, exp[8*(4-i) +: 8]); end
    end
    checks++; if (busy !== 1'b0 || txValid !== 1'b0) begin failures++; $display("[TB] FAIL load_done busy=%b txv=%b exp=00", busy, txValid); end
  endtask

  task automatic test_bad_cmd();
    bit ok;
    logic [7:0] b;
    errClr = 1'b1;
    applyStimulus(8'h33, ok);
    errClr = 1'b0;
    checks++; if (errFlag !== 1'b1) begin failures++; $display("[TB] FAIL badcmd_set_prio got=%b exp=1", errFlag); end
    checks++; if (memReq !== 1'b0 || busy !== 1'b1) begin failures++; $display("[TB] FAIL badcmd_state req=%b busy=%b exp=0 1", memReq, busy); end
    recv_byte(b, ok);
    checks++; if (!ok || b !== 8'h45) begin failures++; $display("[TB] FAIL badcmd_resp got=%h exp=45", b); end
    checks++; if (txValid !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL badcmd_done txv=%b busy=%b exp=00", txValid, busy); end
    errClr = 1'b1;
    tick();
    errClr = 1'b0;
    checks++; if (errFlag !== 1'b0) begin failures++; $display("[TB] FAIL err_clear got=%b exp=0", errFlag); end
  endtask

  task automatic test_bus_err();
    bit ok;
    logic [7:0] b;
    send_pkt(72'h52_00000008, 5, ok);
    wait_req(ok);
    mem_respond(32'hFFFF_FFFF, 1'b1, 1'b1);
    recv_byte(b, ok);
    checks++; if (!ok || b !== 8'h45) begin failures++; $display("[TB] FAIL buserr_resp got=%h exp=45", b); end
    checks++; if (txValid !== 1'b0 || busy !== 1'b0 || errFlag !== 1'b1) begin failures++; $display("[TB] FAIL buserr_done txv=%b busy=%b err=%b exp=0 0 1", txValid, busy, errFlag); end
    errClr = 1'b1;
    tick();
    errClr = 1'b0;
  endtask

  task automatic test_timeout();
    bit ok;
    bit sawTx;
    int idleAt;
    logic [7:0] b;
    logic [39:0] exp;
    sawTx  = 1'b0;
    idleAt = 0;
    send_pkt(72'h5200, 2, ok);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (!busy && idleAt == 0) idleAt = i;
      if (txValid) sawTx = 1'b1;
    end
    checks++; if (idleAt != 16) begin failures++; $display("[TB] FAIL timeout_cycle got=%0d exp=16", idleAt); end
    checks++; if (sawTx !== 1'b0 || errFlag !== 1'b1) begin failures++; $display("[TB] FAIL timeout_flags tx=%b err=%b exp=0 1", sawTx, errFlag); end
    errClr = 1'b1;
    tick();
    errClr = 1'b0;
    exp = 40'h4B_CAFEF00D;
    send_pkt(72'h52_00000000, 5, ok);
    wait_req(ok);
    checks++; if (!ok || memAddr !== 32'h0) begin failures++; $display("[TB] FAIL timeout_next_req ok=%b addr=%h exp=1 0", ok, memAddr); end
    mem_respond(32'hCAFE_F00D, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      recv_byte(b, ok);
      checks++; if (!ok || b !== exp[8*(4-i) +: 8]) begin failures++; $display("[TB] FAIL timeout_next_byte%0d got=%h exp=%h", i, b, exp[8*(4-i) +: 8]); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit stable;
    logic [7:0] b;
    logic [31:0] exp;
    exp = 32'hA5C3_0F96;
    send_pkt(72'h52_00003000, 5, ok);
    wait_req(ok);
    stable = ok;
    for (int i = 0; i < 5; i++) begin
      if (memReq !== 1'b1 || memAddr !== 32'h0000_3000 || memWe !== 1'b0) stable = 1'b0;
      tick();
    end
    checks++; if (!stable) begin failures++; $display("[TB] FAIL bp_req_hold got=unstable exp=stable req=%b addr=%h", memReq, memAddr); end
    mem_respond(exp, 1'b0, 1'b0);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (txValid !== 1'b1 || txData !== 8'h4B) stable = 1'b0;
      tick();
    end
    checks++; if (!stable) begin failures++; $display("[TB] FAIL bp_hdr_hold txv=%b data=%h exp=1 4b", txValid, txData); end
    recv_byte(b, ok);
    checks++; if (!ok || b !== 8'h4B) begin failures++; $display("[TB] FAIL bp_hdr got=%h exp=4b", b); end
    stable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (txValid !== 1'b1 || txData !== 8'hA5) stable = 1'b0;
      tick();
    end
    checks++; if (!stable) begin failures++; $display("[TB] FAIL bp_data_hold txv=%b data=%h exp=1 a5", txValid, txData); end
    for (int i = 0; i < 4; i++) begin
      recv_byte(b, ok);
      checks++; if (!ok || b !== exp[8*(3-i) +: 8]) begin failures++; $display("[TB] FAIL bp_byte%0d got=%h exp=%h", i, b, exp[8*(3-i) +: 8]); end
    end
    checks++; if (txValid !== 1'b0) begin failures++; $display("[TB] FAIL bp_no_extra got=%b exp=0", txValid); end
  endtask

  task automatic test_enable();
    bit ok;
    en = 1'b0;
    applyStimulus(8'h52, ok);
    checks++; if (!ok || busy !== 1'b0) begin failures++; $display("[TB] FAIL en_drop ok=%b busy=%b exp=1 0", ok, busy); end
    en = 1'b1;
    send_pkt(72'h5200, 2, ok);
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL en_addr busy=%b exp=1", busy); end
    en = 1'b0;
    tick();
    en = 1'b1;
    checks++; if (busy !== 1'b0 || errFlag !== 1'b0 || txValid !== 1'b0) begin failures++; $display("[TB] FAIL en_abort busy=%b err=%b txv=%b exp=000", busy, errFlag, txValid); end
  endtask

  task automatic test_reset_midop();
    bit ok;
    logic [7:0] b;
    send_pkt(72'h57_00000040_11223344, 9, ok);
    wait_req(ok);
    rst = 1'b1;
    #1;
    checks++; if (memReq !== 1'b0 || busy !== 1'b0 || txValid !== 1'b0) begin failures++; $display("[TB] FAIL midrst req=%b busy=%b txv=%b exp=000", memReq, busy, txValid); end
    tick();
    rst = 1'b0;
    tick();
    send_pkt(72'h57_00000044_55667788, 9, ok);
    wait_req(ok);
    checks++; if (!ok || memAddr !== 32'h44 || memWdata !== 32'h5566_7788) begin failures++; $display("[TB] FAIL midrst_store addr=%h wdata=%h exp=00000044 55667788", memAddr, memWdata); end
    mem_respond(32'h0, 1'b0, 1'b0);
    recv_byte(b, ok);
    checks++; if (!ok || b !== 8'h4B || busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_resp got=%h busy=%b exp=4b 0", b, busy); end
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b1;
    rxData    = 8'h00;
    rxValid   = 1'b0;
    txReady   = 1'b0;
    memGnt    = 1'b0;
    memRvalid = 1'b0;
    memRdata  = 32'h0;
    memErr    = 1'b0;
    errClr    = 1'b0;
    test_reset();
    test_store();
    test_load();
    test_bad_cmd();
    test_bus_err();
    test_timeout();
    test_backpressure();
    test_enable();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
